vga_timing_monitor: RTL

- Receive-side counterpart of the VGA timing generator.
- Consumes the generator's hsync/vsync/valid/pixel stream and recovers the pixel position.
- Checks every timing interval against the 640x480@60 parameters and reports lock, frame/line strobes and errors.
- Used on the board for debug LEDs and in simulation as a scoreboard for the display pipeline.

---
 rtl/vga_timing_monitor.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: recovers pixel position and scores every sync/active interval.
// Optional per-frame pixel checksum is built only when VGA_MON_CHECKSUM_EN is defined.
module vga_timing_monitor #(
  parameter int unsigned HD       = 640,
  parameter int unsigned HS       = 96,
  parameter int unsigned HT       = 800,
  parameter int unsigned VD       = 480,
  parameter int unsigned VS       = 2,
  parameter int unsigned VT       = 525,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [11:0] pixel,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        locked,
  output logic        line_start,
  output logic        frame_start,
  output logic        err_pulse,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_sum
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_p_q, vs_p_q, val_p_q;
  logic [9:0]  hclk_q, hclk_d, hs_w_q, hs_w_d, act_w_q, act_w_d;
  logic [9:0]  line_q, line_d, vs_w_q, vs_w_d, act_lines_q, act_lines_d;
  logic [9:0]  h_pos_q, h_pos_d, v_pos_q, v_pos_d;
  logic        first_pend_q, first_pend_d, pend;
  logic        locked_q, locked_d, line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d, err_pulse_q, err_pulse_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        hs_act, vs_act, hs_rise, hs_fall, vs_rise, vs_fall;
  logic        val_rise, val_fall, viol;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

  assign hs_act   = (hsync == SYNC_ACT);
  assign vs_act   = (vsync == SYNC_ACT);
  assign hs_rise  = hs_act & (hs_p_q != SYNC_ACT);
  assign hs_fall  = ~hs_act & (hs_p_q == SYNC_ACT);
  assign vs_rise  = vs_act & (vs_p_q != SYNC_ACT);
  assign vs_fall  = ~vs_act & (vs_p_q == SYNC_ACT);
  assign val_rise = valid & ~val_p_q;
  assign val_fall = ~valid & val_p_q;
  // a vsync release and a valid rise in the same cycle still start row 0
  assign pend     = first_pend_q | vs_fall;

  always_comb begin
    hclk_d  = hs_rise ? 10'd1 : sat_inc(hclk_q);
    hs_w_d  = hs_rise ? 10'd1 : (hs_act ? sat_inc(hs_w_q) : '0);
    act_w_d = val_rise ? 10'd1 : (valid ? sat_inc(act_w_q) : '0);
    h_pos_d = val_rise ? '0 : (valid ? h_pos_q + 10'd1 : h_pos_q);

    // edge counters restart on vsync assert, counting a coincident hsync/valid edge
    if (vs_rise)      line_d = {9'd0, hs_rise};
    else if (hs_rise) line_d = sat_inc(line_q);
    else              line_d = line_q;

    if (vs_rise)      vs_w_d = {9'd0, hs_rise};
    else if (!vs_act) vs_w_d = '0;
    else if (hs_rise) vs_w_d = sat_inc(vs_w_q);
    else              vs_w_d = vs_w_q;

    if (vs_rise)       act_lines_d = {9'd0, val_rise};
    else if (val_rise) act_lines_d = sat_inc(act_lines_q);
    else               act_lines_d = act_lines_q;

    v_pos_d       = val_rise ? (pend ? '0 : v_pos_q + 10'd1) : v_pos_q;
    first_pend_d  = pend & ~val_rise;
    line_start_d  = val_rise;
    frame_start_d = val_rise & pend;
  end

  always_comb begin
    viol = (hs_rise  && (hclk_q  != 10'(HT))) ||
           (hs_fall  && (hs_w_q  != 10'(HS))) ||
           (val_fall && (act_w_q != 10'(HD))) ||
           (vs_fall  && (vs_w_q  != 10'(VS))) ||
           (vs_rise  && ((line_q != 10'(VT)) || (act_lines_q != 10'(VD))));

    state_d     = state_q;
    err_pulse_d = 1'b0;
    unique case (state_q)
      SEARCH: if (vs_rise) state_d = ALIGN;
      ALIGN: begin
        if (viol)         state_d = SEARCH;
        else if (vs_rise) state_d = LOCKED;
      end
      LOCKED: begin
        if (viol) begin
          state_d     = SEARCH;
          err_pulse_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    err_cnt_d = (err_pulse_d && (err_cnt_q != '1)) ? err_cnt_q + 8'd1 : err_cnt_q;
    locked_d  = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= SEARCH;
      hs_p_q        <= SYNC_ACT;
      vs_p_q        <= SYNC_ACT;
      val_p_q       <= 1'b0;
      hclk_q        <= '0;
      hs_w_q        <= '0;
      act_w_q       <= '0;
      line_q        <= '0;
      vs_w_q        <= '0;
      act_lines_q   <= '0;
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      first_pend_q  <= 1'b0;
      locked_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      hs_p_q        <= hsync;
      vs_p_q        <= vsync;
      val_p_q       <= valid;
      hclk_q        <= hclk_d;
      hs_w_q        <= hs_w_d;
      act_w_q       <= act_w_d;
      line_q        <= line_d;
      vs_w_q        <= vs_w_d;
      act_lines_q   <= act_lines_d;
      h_pos_q       <= h_pos_d;
      v_pos_q       <= v_pos_d;
      first_pend_q  <= first_pend_d;
      locked_q      <= locked_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      err_pulse_q   <= err_pulse_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign h_pos       = h_pos_q;
  assign v_pos       = v_pos_q;
  assign locked      = locked_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;

`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;

  always_comb begin
    acc_d       = acc_q;
    frame_sum_d = frame_sum_q;
    if (vs_rise) begin
      frame_sum_d = acc_q;
      acc_d       = valid ? {4'h0, pixel} : '0;
    end else if (valid) begin
      acc_d = acc_q + {4'h0, pixel};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  logic unused_pixel;
  assign unused_pixel = ^pixel;
  assign frame_sum    = '0;
`endif

endmodule
